// File: rtl/mem_stage.sv
// Memory access stage: passes ALU/CSR results through, and runs load/store
// transactions on a simple req/ack data bus while stalling the front end.
module mem_stage (
    input  logic        clk,
    input  logic        rst,

    input  logic        valid_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_wen_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [31:0] csr_waddr_i,
    input  logic        csr_wen_i,

    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_be_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,

    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wen_o,
    output logic        mem_re_o,
    output logic [31:0] ram_data_o,
    output logic [31:0] csr_wdata_o,
    output logic [31:0] csr_waddr_o,
    output logic        csr_wen_o,

    output logic        stall_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        misalign_q;

    logic        is_mem;
    logic        is_store;
    logic        fault;
    logic        mem_fault;
    logic        mem_start;
    logic [1:0]  off;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // A load with mem_we_i also set is still a load.
    assign is_mem   = valid_i & (mem_re_i | mem_we_i);
    assign is_store = mem_we_i & ~mem_re_i;
    assign off      = rd_data_i[1:0];

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        fault = 1'b0;
        case (funct3_i)
            3'b000:  fault = 1'b0;
            3'b001:  fault = off[0];
            3'b010:  fault = |off;
            3'b100:  fault = is_store;
            3'b101:  fault = is_store | off[0];
            default: fault = 1'b1;
        endcase
    end

    assign mem_fault = is_mem & fault;
    assign mem_start = is_mem & ~fault;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data_i;
        if (is_store) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << off;
                    wdata_next = {4{store_data_i[7:0]}};
                end
                2'b01: begin
                    be_next    = off[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{store_data_i[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = store_data_i;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the latched transaction registers are cleared on reset so no stale word can leak after a fault.
            state      <= IDLE;
            addr_q     <= '0;
            off_q      <= '0;
            f3_q       <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            // Registered so the trap logic sees a clean one-cycle pulse.
            misalign_q <= (state == IDLE) & mem_fault;
            case (state)
                IDLE: begin
                    if (mem_start) begin
                        addr_q  <= rd_data_i[31:2];
                        off_q   <= off;
                        f3_q    <= funct3_i;
                        we_q    <= is_store;
                        be_q    <= be_next;
                        wdata_q <= wdata_next;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (dbus_ack_i) begin
                        rdata_q <= dbus_rdata_i;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        load_byte = rdata_q[7:0];
        case (off_q)
            2'd0: load_byte = rdata_q[7:0];
            2'd1: load_byte = rdata_q[15:8];
            2'd2: load_byte = rdata_q[23:16];
            2'd3: load_byte = rdata_q[31:24];
            default: load_byte = rdata_q[7:0];
        endcase
        load_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        rd_addr_o   = rd_addr_i;
        rd_data_o   = rd_data_i;
        rd_wen_o    = valid_i & rd_wen_i;
        csr_wdata_o = csr_wdata_i;
        csr_waddr_o = csr_waddr_i;
        csr_wen_o   = valid_i & csr_wen_i;
        mem_re_o    = 1'b0;
        ram_data_o  = '0;
        stall_o     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_start) begin
                    stall_o   = 1'b1;
                    rd_wen_o  = 1'b0;
                    csr_wen_o = 1'b0;
                end else if (mem_fault) begin
                    rd_wen_o  = 1'b0;
                    csr_wen_o = 1'b0;
                end
            end
            BUSY: begin
                stall_o   = 1'b1;
                rd_wen_o  = 1'b0;
                csr_wen_o = 1'b0;
            end
            DONE: begin
                mem_re_o   = mem_re_i;
                ram_data_o = we_q ? 32'd0 : load_data;
            end
            default: stall_o = 1'b0;
        endcase
    end

    assign dbus_req_o   = (state == BUSY);
    assign dbus_we_o    = dbus_req_o & we_q;
    assign dbus_be_o    = dbus_req_o ? be_q : 4'b0000;
    assign dbus_addr_o  = {addr_q, 2'b00};
    assign dbus_wdata_o = wdata_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for single-cycle pass-through
// and fault cases, plus hand-written load/store and reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [2:0]  funct3_i;
    logic [31:0] store_data_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_waddr_i;
    logic        csr_wen_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        mem_re_o;
    logic [31:0] ram_data_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_waddr_o;
    logic        csr_wen_o;
    logic        stall_o;
    logic        misalign_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_i    (rd_data_i),
        .rd_wen_i     (rd_wen_i),
        .mem_re_i     (mem_re_i),
        .mem_we_i     (mem_we_i),
        .funct3_i     (funct3_i),
        .store_data_i (store_data_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_waddr_i  (csr_waddr_i),
        .csr_wen_i    (csr_wen_i),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_be_o    (dbus_be_o),
        .dbus_ack_i   (dbus_ack_i),
        .dbus_rdata_i (dbus_rdata_i),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .rd_wen_o     (rd_wen_o),
        .mem_re_o     (mem_re_o),
        .ram_data_o   (ram_data_o),
        .csr_wdata_o  (csr_wdata_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wen_o    (csr_wen_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic        cwen;
        logic [31:0] cdata;
        logic        e_wen;
        logic        e_cwen;
        logic        e_stall;
        logic        e_mis;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        valid_i = 1'b0; rd_wen_i = 1'b0; mem_re_i = 1'b0; mem_we_i = 1'b0;
        csr_wen_i = 1'b0; funct3_i = 3'b000; rd_data_i = '0; rd_addr_i = '0;
    endtask

    // Runs one aligned load/store; waits = number of non-ack BUSY cycles.
    task automatic mem_op(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic re, input logic we, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int waits, input logic [3:0] ebe,
                          input logic [31:0] ewdata, input logic [31:0] eram);
        int stalls;
        stalls = 0;
        valid_i = 1'b1; rd_addr_i = 5'd9; rd_data_i = addr; rd_wen_i = re;
        mem_re_i = re; mem_we_i = we; funct3_i = f3; store_data_i = sdata; csr_wen_i = 1'b0;
        #1;
        check({name, "_idle_req"}, dbus_req_o, 1'b0);
        check({name, "_idle_wen"}, rd_wen_o, 1'b0);
        if (stall_o) stalls++;
        tick();
        for (int i = 0; i <= waits; i++) begin
            dbus_ack_i   = (i == waits);
            dbus_rdata_i = (i == waits) ? rdata : 32'hBAD0_BAD0;
            #1;
            check({name, "_busy_req"}, dbus_req_o, 1'b1);
            check({name, "_busy_addr"}, dbus_addr_o, addr & 32'hFFFF_FFFC);
            check({name, "_busy_we"}, dbus_we_o, we & ~re);
            check({name, "_busy_wen"}, rd_wen_o, 1'b0);
            if (!re) begin
                check({name, "_busy_be"}, {28'd0, dbus_be_o}, {28'd0, ebe});
                check({name, "_busy_wdata"}, dbus_wdata_o, ewdata);
            end
            if (stall_o) stalls++;
            tick();
        end
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = 32'h5555_5555;
        #1;
        check({name, "_done_req"}, dbus_req_o, 1'b0);
        check({name, "_done_be"}, {28'd0, dbus_be_o}, 32'd0);
        check({name, "_done_stall"}, stall_o, 1'b0);
        check({name, "_done_mem_re"}, mem_re_o, re);
        check({name, "_done_wen"}, rd_wen_o, re);
        if (re) check({name, "_done_ram"}, ram_data_o, eram);
        if (stall_o) stalls++;
        check({name, "_stall_cycles"}, stalls, waits + 2);
        tick();
        bubble();
        #1;
        check({name, "_back_idle"}, stall_o, 1'b0);
        tick();
        check({name, "_ack_ignored"}, dbus_req_o, 1'b0);
        dbus_ack_i = 1'b0;
    endtask

    initial begin
        //               valid rd     data            wen re  we  f3      cwen cdata          e_wen e_cwen e_stall e_mis
        vecs[0]  = '{1'b1, 5'd5, 32'h0000_1234, 1, 0, 0, 3'b000, 0, 32'h0,          1, 0, 0, 0};
        vecs[1]  = '{1'b0, 5'd6, 32'h0000_0042, 1, 0, 0, 3'b000, 1, 32'h1111,       0, 0, 0, 0};
        vecs[2]  = '{1'b1, 5'd0, 32'h0000_0000, 0, 0, 0, 3'b000, 1, 32'hDEAD_BEEF,  0, 1, 0, 0};
        vecs[3]  = '{1'b1, 5'd3, 32'h0000_0101, 1, 1, 0, 3'b010, 1, 32'h0,          0, 0, 0, 1};
        vecs[4]  = '{1'b1, 5'd7, 32'h0000_0077, 1, 0, 0, 3'b000, 0, 32'h0,          1, 0, 0, 0};
        vecs[5]  = '{1'b1, 5'd3, 32'h0000_0102, 0, 0, 1, 3'b010, 0, 32'h0,          0, 0, 0, 1};
        vecs[6]  = '{1'b1, 5'd4, 32'h0000_0103, 1, 1, 0, 3'b001, 0, 32'h0,          0, 0, 0, 1};
        vecs[7]  = '{1'b1, 5'd4, 32'h0000_0001, 0, 0, 1, 3'b001, 0, 32'h0,          0, 0, 0, 1};
        vecs[8]  = '{1'b1, 5'd8, 32'h0000_0100, 1, 1, 0, 3'b011, 0, 32'h0,          0, 0, 0, 1};
        vecs[9]  = '{1'b1, 5'd8, 32'h0000_0100, 0, 0, 1, 3'b100, 0, 32'h0,          0, 0, 0, 1};
        vecs[10] = '{1'b0, 5'd8, 32'h0000_0101, 1, 1, 0, 3'b010, 0, 32'h0,          0, 0, 0, 0};

        rst = 1'b1;
        bubble();
        store_data_i = '0; csr_wdata_i = '0; csr_waddr_i = 32'h300;
        dbus_ack_i = 1'b0; dbus_rdata_i = '0;
        repeat (2) tick();
        check("reset_req", dbus_req_o, 1'b0);
        check("reset_misalign", misalign_o, 1'b0);
        check("reset_stall", stall_o, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            valid_i = vecs[i].valid; rd_addr_i = vecs[i].rd; rd_data_i = vecs[i].data;
            rd_wen_i = vecs[i].wen; mem_re_i = vecs[i].re; mem_we_i = vecs[i].we;
            funct3_i = vecs[i].f3; csr_wen_i = vecs[i].cwen; csr_wdata_i = vecs[i].cdata;
            #1;
            check($sformatf("vec%0d_rd_wen", i), rd_wen_o, vecs[i].e_wen);
            check($sformatf("vec%0d_csr_wen", i), csr_wen_o, vecs[i].e_cwen);
            check($sformatf("vec%0d_stall", i), stall_o, vecs[i].e_stall);
            check($sformatf("vec%0d_req", i), dbus_req_o, 1'b0);
            check($sformatf("vec%0d_mem_re", i), mem_re_o, 1'b0);
            check($sformatf("vec%0d_ram", i), ram_data_o, 32'd0);
            check($sformatf("vec%0d_rd_addr", i), rd_addr_o, vecs[i].rd);
            check($sformatf("vec%0d_rd_data", i), rd_data_o, vecs[i].data);
            check($sformatf("vec%0d_csr_wdata", i), csr_wdata_o, vecs[i].cdata);
            tick();
            check($sformatf("vec%0d_misalign", i), misalign_o, vecs[i].e_mis);
        end
        bubble();
        tick();

        mem_op("lb_103",  3'b000, 32'h0000_0103, 1, 0, 32'h0, 32'h80FF_0011, 1, 4'b0000, 32'h0, 32'hFFFF_FF80);
        mem_op("sh_202",  3'b001, 32'h0000_0202, 0, 1, 32'h0000_ABCD, 32'h0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        mem_op("sh_200",  3'b001, 32'h0000_0200, 0, 1, 32'h1234_ABCD, 32'h0, 0, 4'b0011, 32'hABCD_ABCD, 32'h0);
        mem_op("sb_101",  3'b000, 32'h0000_0101, 0, 1, 32'h1234_5678, 32'h0, 2, 4'b0010, 32'h7878_7878, 32'h0);
        mem_op("sw_104",  3'b010, 32'h0000_0104, 0, 1, 32'hCAFE_F00D, 32'h0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        mem_op("lbu_100", 3'b100, 32'h0000_0100, 1, 0, 32'h0, 32'h1234_A5C3, 0, 4'b0000, 32'h0, 32'h0000_00C3);
        mem_op("lb_100",  3'b000, 32'h0000_0100, 1, 0, 32'h0, 32'h1234_A5C3, 0, 4'b0000, 32'h0, 32'hFFFF_FFC3);
        mem_op("lh_102",  3'b001, 32'h0000_0102, 1, 0, 32'h0, 32'h8001_7FFF, 0, 4'b0000, 32'h0, 32'hFFFF_8001);
        mem_op("lhu_102", 3'b101, 32'h0000_0102, 1, 0, 32'h0, 32'h8001_7FFF, 0, 4'b0000, 32'h0, 32'h0000_8001);
        mem_op("lh_100",  3'b001, 32'h0000_0100, 1, 0, 32'h0, 32'h8001_7FFF, 0, 4'b0000, 32'h0, 32'h0000_7FFF);
        mem_op("lw_104",  3'b010, 32'h0000_0104, 1, 0, 32'h0, 32'hDEAD_BEEF, 3, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        mem_op("rewe_108", 3'b010, 32'h0000_0108, 1, 1, 32'h0, 32'h0BAD_F00D, 0, 4'b0000, 32'h0, 32'h0BAD_F00D);

        // A fault registered in the same edge as reset must not pulse.
        valid_i = 1'b1; rd_data_i = 32'h0000_0101; mem_re_i = 1'b1; funct3_i = 3'b010;
        rst = 1'b1;
        tick();
        check("rst_clears_misalign", misalign_o, 1'b0);
        rst = 1'b0;
        bubble();
        tick();

        // LHU caught in BUSY by reset, followed by a stray ack.
        valid_i = 1'b1; rd_addr_i = 5'd10; rd_data_i = 32'h0000_0002; rd_wen_i = 1'b1;
        mem_re_i = 1'b1; funct3_i = 3'b101;
        #1;
        check("lhu_rst_idle_stall", stall_o, 1'b1);
        tick();
        check("lhu_rst_busy_req", dbus_req_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bubble();
        #1;
        check("lhu_rst_req_dropped", dbus_req_o, 1'b0);
        check("lhu_rst_stall", stall_o, 1'b0);
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
        #1;
        check("lhu_rst_stray_wen", rd_wen_o, 1'b0);
        tick();
        dbus_ack_i = 1'b0;
        check("lhu_rst_after_req", dbus_req_o, 1'b0);
        check("lhu_rst_after_mem_re", mem_re_o, 1'b0);
        check("lhu_rst_after_ram", ram_data_o, 32'd0);
        check("lhu_rst_after_wen", rd_wen_o, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
